// File: rtl/mlsd_code_buffer_if.sv
// Handshake/bus bundle for the MLSD code buffer: the incoming frame side plus the window outputs.
interface mlsd_code_buffer_if #(
   parameter int unsigned numChannels  = 16,
   parameter int unsigned codeBitwidth = 10,
   parameter int unsigned bufferDepth  = 3,
   parameter int unsigned tagWidth     = 8
);
   logic [numChannels-1:0][codeBitwidth-1:0]             in_codes;
   logic                                                 in_valid;
   logic                                                 flush;
   logic [numChannels*bufferDepth-1:0][codeBitwidth-1:0] flat_codes;
   logic                                                 flat_valid;
   logic [tagWidth-1:0]                                  frame_tag;

   modport master (
      output in_codes, in_valid, flush,
      input  flat_codes, flat_valid, frame_tag
   );

   modport slave (
      input  in_codes, in_valid, flush,
      output flat_codes, flat_valid, frame_tag
   );
endinterface

// File: rtl/mlsd_code_buffer.sv
// Sliding window of the last bufferDepth ADC frames feeding the MLSD decision stage.
// Slot 0 (lowest flat index) is the oldest frame; every output comes straight from a flop.
module mlsd_code_buffer #(
   parameter int unsigned numChannels  = 16,
   parameter int unsigned codeBitwidth = 10,
   parameter int unsigned bufferDepth  = 3,
   parameter int unsigned tagWidth     = 8
) (
   input logic                  clk,
   input logic                  rstb,
   mlsd_code_buffer_if.slave    bus
);
   localparam int unsigned CNT_W = $clog2(bufferDepth + 1);
   localparam int unsigned NC    = numChannels;
   localparam int unsigned NW    = numChannels * bufferDepth;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(bufferDepth);

   logic [NW-1:0][codeBitwidth-1:0] win_q, win_d;
   logic [CNT_W-1:0]                fill_q, fill_d;
   logic                            valid_q, valid_d;
   logic [tagWidth-1:0]             tag_q, tag_d;

   // Next state: flush clears the window and fill state (tag kept), otherwise an accept shifts in a frame.
   always_comb begin
      win_d   = win_q;
      fill_d  = fill_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      if (bus.flush) begin
         win_d   = '0;
         fill_d  = '0;
         valid_d = 1'b0;
      end else if (bus.in_valid) begin
         win_d[NW-NC-1:0]   = win_q[NW-1:NC];
         win_d[NW-1 -: NC]  = bus.in_codes;
         fill_d             = (fill_q == FULL) ? fill_q : fill_q + CNT_W'(1);
         valid_d            = (fill_d == FULL);
         tag_d              = tag_q + tagWidth'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         win_q   <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else begin
         win_q   <= win_d;
         fill_q  <= fill_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign bus.flat_codes = win_q;
   assign bus.flat_valid = valid_q;
   assign bus.frame_tag  = tag_q;
endmodule

// File: tb/tb_mlsd_code_buffer.sv
// Bench for mlsd_code_buffer: frame-history queue model checked every cycle, plus directed literal checks.
module tb_mlsd_code_buffer;
   localparam int unsigned NC = 16;
   localparam int unsigned CW = 10;
   localparam int unsigned BD = 3;
   localparam int unsigned TW = 8;

   typedef logic [NC-1:0][CW-1:0]    frame_t;
   typedef logic [NC*BD-1:0][CW-1:0] flat_t;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   logic cmp_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   mlsd_code_buffer_if #(.numChannels(NC), .codeBitwidth(CW), .bufferDepth(BD), .tagWidth(TW)) bus ();

   mlsd_code_buffer #(.numChannels(NC), .codeBitwidth(CW), .bufferDepth(BD), .tagWidth(TW)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Model: list of accepted frames since the last reset/flush (last BD kept) and a tag counter.
   frame_t          hist[$];
   logic [TW-1:0]   mtag = '0;

   always @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         hist.delete();
         mtag = '0;
      end else if (bus.flush) begin
         hist.delete();
      end else if (bus.in_valid) begin
         hist.push_back(bus.in_codes);
         if (hist.size() > BD) void'(hist.pop_front());
         mtag = mtag + 1'b1;
      end
   end

   function automatic flat_t model_flat();
      flat_t f = '0;
      for (int k = 0; k < BD; k++) begin
         int idx = hist.size() - BD + k;
         if (idx >= 0) f[k*NC +: NC] = hist[idx];
      end
      return f;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Compare process: DUT outputs against the model, sampled away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_flat_codes", 512'(bus.flat_codes), 512'(model_flat()));
         chk("cyc_flat_valid", 512'(bus.flat_valid), 512'(hist.size() == BD));
         chk("cyc_frame_tag",  512'(bus.frame_tag),  512'(mtag));
      end
   end

   function automatic frame_t mk(input int f);
      frame_t fr;
      for (int i = 0; i < NC; i++) fr[i] = CW'(16*f + i);
      return fr;
   endfunction

   function automatic frame_t rnd_frame();
      frame_t fr;
      for (int i = 0; i < NC; i++) fr[i] = CW'($urandom);
      return fr;
   endfunction

   // One clock: drive inputs after the negedge, then return just after the posedge.
   task automatic cycle(input logic v, input logic fl, input frame_t fr);
      @(negedge clk);
      #1;
      bus.in_valid = v;
      bus.flush    = fl;
      bus.in_codes = fr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rstb = 1'b0;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      @(negedge clk);
      #1;
      rstb = 1'b1;
   endtask

   frame_t ext;
   flat_t  fl_tmp;

   initial begin
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.in_codes = '0;
      #1;
      cmp_en = 1'b1;
      @(negedge clk);
      #1;
      rstb = 1'b1;

      // Fill with continuous accepts.
      cycle(1'b1, 1'b0, mk(1));
      cycle(1'b1, 1'b0, mk(2));
      chk("t2_valid_before_full", 512'(bus.flat_valid), 512'(0));
      cycle(1'b1, 1'b0, mk(3));
      fl_tmp = bus.flat_codes;
      chk("t2_valid_full", 512'(bus.flat_valid), 512'(1));
      chk("t2_code0",  512'(fl_tmp[0]),  512'(16));
      chk("t2_code47", 512'(fl_tmp[47]), 512'(63));
      chk("t2_tag",    512'(bus.frame_tag), 512'(3));

      // Asynchronous reset mid-traffic takes effect without a clock edge.
      @(negedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_codes = mk(4);
      #1;
      rstb = 1'b0;
      #1;
      chk("t1_codes", 512'(bus.flat_codes), 512'(0));
      chk("t1_valid", 512'(bus.flat_valid), 512'(0));
      chk("t1_tag",   512'(bus.frame_tag),  512'(0));
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      rstb = 1'b1;

      // Stall between the second and third frame.
      cycle(1'b1, 1'b0, mk(1));
      cycle(1'b1, 1'b0, mk(2));
      for (int s = 0; s < 5; s++) begin
         cycle(1'b0, 1'b0, mk(9));
         chk("t3_stall_valid", 512'(bus.flat_valid), 512'(0));
         chk("t3_stall_tag",   512'(bus.frame_tag),  512'(2));
      end
      cycle(1'b1, 1'b0, mk(3));
      chk("t3_valid_after_f3", 512'(bus.flat_valid), 512'(1));
      fl_tmp = bus.flat_codes;
      chk("t3_code16", 512'(fl_tmp[16]), 512'(32));

      // Flush with a simultaneous frame: frame dropped, tag held.
      cycle(1'b1, 1'b0, mk(4));
      cycle(1'b1, 1'b1, mk(5));
      chk("t4_codes", 512'(bus.flat_codes), 512'(0));
      chk("t4_valid", 512'(bus.flat_valid), 512'(0));
      chk("t4_tag",   512'(bus.frame_tag),  512'(4));
      cycle(1'b1, 1'b0, mk(6));
      fl_tmp = bus.flat_codes;
      chk("t4_newest", 512'(fl_tmp[47]), 512'(111));
      chk("t4_oldest", 512'(fl_tmp[0]),  512'(0));

      // Signed extremes walk from newest slot to oldest slot bit-exact.
      ext = '0;
      ext[0] = 10'h200;
      ext[1] = 10'h1FF;
      cycle(1'b1, 1'b0, ext);
      fl_tmp = bus.flat_codes;
      chk("t6_new_neg", 512'(fl_tmp[32]), 512'(10'h200));
      chk("t6_new_pos", 512'(fl_tmp[33]), 512'(10'h1FF));
      cycle(1'b1, 1'b0, mk(7));
      cycle(1'b1, 1'b0, mk(8));
      fl_tmp = bus.flat_codes;
      chk("t6_old_neg", 512'(fl_tmp[0]), 512'(10'h200));
      chk("t6_old_pos", 512'(fl_tmp[1]), 512'(10'h1FF));
      chk("t6_valid",   512'(bus.flat_valid), 512'(1));

      // Tag wrap over 257 accepts from reset.
      do_reset();
      for (int n = 1; n <= 257; n++) begin
         cycle(1'b1, 1'b0, rnd_frame());
         if (n == 255) chk("t5_tag_255", 512'(bus.frame_tag), 512'(255));
         if (n == 256) chk("t5_tag_256", 512'(bus.frame_tag), 512'(0));
         if (n == 257) chk("t5_tag_257", 512'(bus.frame_tag), 512'(1));
      end

      // Randomized traffic with occasional flush and reset pulses.
      for (int n = 0; n < 800; n++) begin
         int r = int'($urandom_range(0, 99));
         if (r < 2) do_reset();
         else cycle(($urandom_range(0, 99) < 70), (r < 7), rnd_frame());
      end

      cycle(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
